// File: rtl/vx_dcache_req_arb.sv
// Per-lane round-robin arbiter that merges NUM_INPUTS requesters onto shared
// dcache request lanes. Each lane has a one-deep registered output stage.
module vx_dcache_req_arb #(
  parameter int NUM_INPUTS      = 2,
  parameter int NUM_REQS        = 4,
  parameter int WORD_SIZE       = 4,
  parameter int TAG_WIDTH       = 8,
  parameter int INST_MOD_BITS   = 3,
  parameter int WORD_ADDR_WIDTH = 30,
  localparam int WORD_WIDTH     = WORD_SIZE * 8,
  localparam int SEL_BITS       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int OUT_TAG_WIDTH  = TAG_WIDTH + SEL_BITS,
  localparam int NL             = NUM_INPUTS * NUM_REQS
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NL-1:0]                       in_valid,
  input  logic [NL-1:0]                       in_rw,
  input  logic [NL*INST_MOD_BITS-1:0]         in_op_mod,
  input  logic [NL-1:0]                       in_is_amo,
  input  logic [NL*WORD_SIZE-1:0]             in_byteen,
  input  logic [NL*WORD_ADDR_WIDTH-1:0]       in_addr,
  input  logic [NL*WORD_WIDTH-1:0]            in_data,
  input  logic [NL*TAG_WIDTH-1:0]             in_tag,
  output logic [NL-1:0]                       in_ready,
  output logic [NUM_REQS-1:0]                 out_valid,
  output logic [NUM_REQS-1:0]                 out_rw,
  output logic [NUM_REQS*INST_MOD_BITS-1:0]   out_op_mod,
  output logic [NUM_REQS-1:0]                 out_is_amo,
  output logic [NUM_REQS*WORD_SIZE-1:0]       out_byteen,
  output logic [NUM_REQS*WORD_ADDR_WIDTH-1:0] out_addr,
  output logic [NUM_REQS*WORD_WIDTH-1:0]      out_data,
  output logic [NUM_REQS*OUT_TAG_WIDTH-1:0]   out_tag,
  input  logic [NUM_REQS-1:0]                 out_ready
);

  // First valid requester at or after ptr, wrapping modulo NUM_INPUTS.
  function automatic logic [SEL_BITS-1:0] pick(input logic [SEL_BITS-1:0] ptr,
                                               input logic [NUM_INPUTS-1:0] v);
    logic [SEL_BITS-1:0]   res;
    logic [NUM_INPUTS-1:0] one_hot;
    logic                  found;
    int                    idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      one_hot = NUM_INPUTS'(1) << idx;
      if (!found && |(v & one_hot)) begin
        res   = SEL_BITS'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready may depend on out_ready combinationally, valid never on ready.
  for (genvar l = 0; l < NUM_REQS; l++) begin : g_lane
    logic [NUM_INPUTS-1:0]                      lane_v, lane_rw, lane_amo;
    logic [NUM_INPUTS-1:0][INST_MOD_BITS-1:0]   lane_op;
    logic [NUM_INPUTS-1:0][WORD_SIZE-1:0]       lane_be;
    logic [NUM_INPUTS-1:0][WORD_ADDR_WIDTH-1:0] lane_addr;
    logic [NUM_INPUTS-1:0][WORD_WIDTH-1:0]      lane_data;
    logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]       lane_tag;

    logic [SEL_BITS-1:0]        sel, rr_q;
    logic                       any_v, en, fire;
    logic                       valid_q, rw_q, amo_q;
    logic [INST_MOD_BITS-1:0]   op_q;
    logic [WORD_SIZE-1:0]       be_q;
    logic [WORD_ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0]      data_q;
    logic [OUT_TAG_WIDTH-1:0]   tag_q;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
      localparam int IDX = i * NUM_REQS + l;
      assign lane_v[i]    = in_valid[IDX];
      assign lane_rw[i]   = in_rw[IDX];
      assign lane_amo[i]  = in_is_amo[IDX];
      assign lane_op[i]   = in_op_mod[IDX*INST_MOD_BITS +: INST_MOD_BITS];
      assign lane_be[i]   = in_byteen[IDX*WORD_SIZE +: WORD_SIZE];
      assign lane_addr[i] = in_addr[IDX*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH];
      assign lane_data[i] = in_data[IDX*WORD_WIDTH +: WORD_WIDTH];
      assign lane_tag[i]  = in_tag[IDX*TAG_WIDTH +: TAG_WIDTH];
      assign in_ready[IDX] = en && any_v && (sel == SEL_BITS'(i));
    end

    assign any_v = |lane_v;
    assign sel   = pick(rr_q, lane_v);
    assign en    = !valid_q || out_ready[l];
    assign fire  = en && any_v;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        rw_q    <= 1'b0;
        amo_q   <= 1'b0;
        op_q    <= '0;
        be_q    <= '0;
        addr_q  <= '0;
        data_q  <= '0;
        tag_q   <= '0;
        rr_q    <= '0;
      end else if (fire) begin
        valid_q <= 1'b1;
        rw_q    <= lane_rw[sel];
        amo_q   <= lane_amo[sel];
        op_q    <= lane_op[sel];
        be_q    <= lane_be[sel];
        addr_q  <= lane_addr[sel];
        data_q  <= lane_data[sel];
        tag_q   <= {sel, lane_tag[sel]};
        rr_q    <= (sel == SEL_BITS'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;
      end else if (en) begin
        // Drained with nothing to refill; payload is left as-is.
        valid_q <= 1'b0;
      end
    end

    assign out_valid[l]                                     = valid_q;
    assign out_rw[l]                                        = rw_q;
    assign out_is_amo[l]                                    = amo_q;
    assign out_op_mod[l*INST_MOD_BITS +: INST_MOD_BITS]     = op_q;
    assign out_byteen[l*WORD_SIZE +: WORD_SIZE]             = be_q;
    assign out_addr[l*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH]   = addr_q;
    assign out_data[l*WORD_WIDTH +: WORD_WIDTH]             = data_q;
    assign out_tag[l*OUT_TAG_WIDTH +: OUT_TAG_WIDTH]        = tag_q;
  end

endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Directed bench for vx_dcache_req_arb: a 2-input/4-lane instance plus a
// 3-input/1-lane instance for pointer wrap-around.
module tb_vx_dcache_req_arb;

  localparam int SB_W = 70;

  logic clk, reset_n;
  int   checks = 0;
  int   errors = 0;

  // 2 inputs x 4 lanes, 30-bit addr, 32-bit data, 8-bit tag -> 9-bit out tag
  logic [7:0]   in_valid, in_rw, in_is_amo, in_ready;
  logic [23:0]  in_op_mod;
  logic [31:0]  in_byteen;
  logic [239:0] in_addr;
  logic [255:0] in_data;
  logic [63:0]  in_tag;
  logic [3:0]   out_valid, out_rw, out_is_amo, out_ready;
  logic [11:0]  out_op_mod;
  logic [15:0]  out_byteen;
  logic [119:0] out_addr;
  logic [127:0] out_data;
  logic [35:0]  out_tag;

  // 3 inputs x 1 lane -> 10-bit out tag
  logic [2:0]  b_in_valid, b_in_rw, b_in_is_amo, b_in_ready;
  logic [8:0]  b_in_op_mod;
  logic [11:0] b_in_byteen;
  logic [89:0] b_in_addr;
  logic [95:0] b_in_data;
  logic [23:0] b_in_tag;
  logic        b_out_valid, b_out_rw, b_out_is_amo, b_out_ready;
  logic [2:0]  b_out_op_mod;
  logic [3:0]  b_out_byteen;
  logic [29:0] b_out_addr;
  logic [31:0] b_out_data;
  logic [9:0]  b_out_tag;

  vx_dcache_req_arb #(.NUM_INPUTS(2), .NUM_REQS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_rw(in_rw), .in_op_mod(in_op_mod), .in_is_amo(in_is_amo),
    .in_byteen(in_byteen), .in_addr(in_addr), .in_data(in_data), .in_tag(in_tag),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_rw(out_rw), .out_op_mod(out_op_mod), .out_is_amo(out_is_amo),
    .out_byteen(out_byteen), .out_addr(out_addr), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready)
  );

  vx_dcache_req_arb #(.NUM_INPUTS(3), .NUM_REQS(1)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_rw(b_in_rw), .in_op_mod(b_in_op_mod), .in_is_amo(b_in_is_amo),
    .in_byteen(b_in_byteen), .in_addr(b_in_addr), .in_data(b_in_data), .in_tag(b_in_tag),
    .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_rw(b_out_rw), .out_op_mod(b_out_op_mod), .out_is_amo(b_out_is_amo),
    .out_byteen(b_out_byteen), .out_addr(b_out_addr), .out_data(b_out_data), .out_tag(b_out_tag),
    .out_ready(b_out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int l, input logic [29:0] a,
                         input logic [31:0] d, input logic [7:0] t);
    in_addr[(i*4+l)*30 +: 30] = a;
    in_data[(i*4+l)*32 +: 32] = d;
    in_tag[(i*4+l)*8 +: 8]    = t;
  endtask

  function automatic logic [SB_W-1:0] req_word(input int i, input int n);
    return {30'(32'h1000 + i*16 + n), 32'(32'hC000_0000 + i*256 + n), 8'(i*16 + n)};
  endfunction

  // scoreboard state
  logic [SB_W-1:0] exp_q0[$], exp_q1[$];
  logic [SB_W-1:0] w, obs;
  logic [8:0]      ot;
  int              cnt0, cnt1, got;
  logic            acc0, acc1;

  initial begin
    reset_n = 1'b0;
    in_valid = '0; in_rw = '0; in_is_amo = '0; in_op_mod = '0; in_byteen = '0;
    in_addr = '0; in_data = '0; in_tag = '0; out_ready = 4'hF;
    b_in_valid = '0; b_in_rw = '0; b_in_is_amo = '0; b_in_op_mod = '0; b_in_byteen = '0;
    b_in_addr = '0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state and idle
    @(negedge clk);
    chk("reset_out_valid", out_valid, 4'h0);
    chk("reset_out_tag", out_tag, 36'h0);
    chk("reset_out_addr0", out_addr[29:0], 30'h0);
    chk("reset_b_valid", b_out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 4'h0);
    chk("idle_in_ready", in_ready, 8'h0);
    @(posedge clk); #1;

    // both inputs on lane 0: grants alternate 0,1,0,1
    set_req(0, 0, 30'h100, 32'hD0, 8'h22);
    set_req(1, 0, 30'h200, 32'hD1, 8'h11);
    in_byteen[16 +: 4] = 4'h3;
    in_rw[4] = 1'b1;
    in_op_mod[12 +: 3] = 3'h5;
    in_valid = 8'h11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_ready_in0", in_ready[0], k % 2 == 0);
      chk("alt_ready_in1", in_ready[4], k % 2 == 1);
      if (k > 0) chk("alt_tag", out_tag[8:0], (k % 2 == 1) ? 9'h022 : 9'h111);
      @(posedge clk); #1;
    end

    // only input 1 valid with rr = 0, then both valid -> input 0
    in_valid = 8'h10;
    @(negedge clk);
    chk("in1_payload_tag", out_tag[8:0], 9'h111);
    chk("in1_payload_addr", out_addr[29:0], 30'h200);
    chk("in1_payload_data", out_data[31:0], 32'hD1);
    chk("in1_payload_byteen", out_byteen[3:0], 4'h3);
    chk("in1_payload_rw", out_rw[0], 1'b1);
    chk("in1_payload_op", out_op_mod[2:0], 3'h5);
    chk("only_in1_ready1", in_ready[4], 1'b1);
    chk("only_in1_ready0", in_ready[0], 1'b0);
    @(posedge clk); #1;
    in_valid = 8'h11;
    @(negedge clk);
    chk("only_in1_out_tag", out_tag[8:0], 9'h111);
    chk("after_only_in1_ready0", in_ready[0], 1'b1);
    chk("after_only_in1_ready1", in_ready[4], 1'b0);
    @(posedge clk); #1;
    in_valid = 8'h00;
    @(negedge clk);
    chk("in0_out_tag", out_tag[8:0], 9'h022);
    chk("in0_out_addr", out_addr[29:0], 30'h100);
    chk("in0_out_rw", out_rw[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_valid0", out_valid[0], 1'b0);
    @(posedge clk); #1;

    // lane 0 stall for 3 cycles while lane 1 streams
    set_req(0, 0, 30'h300, 32'hD3, 8'h33);
    set_req(1, 0, 30'h310, 32'hD4, 8'h66);
    set_req(0, 1, 30'h400, 32'hE0, 8'h44);
    set_req(1, 1, 30'h410, 32'hE1, 8'h55);
    in_rw[4] = 1'b0;
    in_valid = 8'h23;
    @(negedge clk);
    chk("pre_stall_ready0", in_ready[0], 1'b1);
    @(posedge clk); #1;
    out_ready = 4'b1110;
    in_valid = 8'h33;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid0", out_valid[0], 1'b1);
      chk("stall_tag0", out_tag[8:0], 9'h033);
      chk("stall_addr0", out_addr[29:0], 30'h300);
      chk("stall_ready_l0", {in_ready[4], in_ready[0]}, 2'b00);
      chk("stream_valid1", out_valid[1], 1'b1);
      chk("stream_tag1", out_tag[17:9], (c % 2 == 0) ? 9'h044 : 9'h155);
      chk("stream_ready_in1", in_ready[5], c % 2 == 0);
      chk("stream_ready_in0", in_ready[1], c % 2 == 1);
      @(posedge clk); #1;
    end
    out_ready = 4'hF;
    @(negedge clk);
    chk("rr_frozen_ready1", in_ready[4], 1'b1);
    chk("rr_frozen_ready0", in_ready[0], 1'b0);
    @(posedge clk); #1;
    in_valid = 8'h00;
    @(negedge clk);
    chk("post_stall_tag0", out_tag[8:0], 9'h166);
    chk("post_stall_addr0", out_addr[29:0], 30'h310);
    @(posedge clk); #1;

    // lane 2 back-to-back with out_ready 1,0,1 against per-input scoreboard
    for (int i = 0; i < 2; i++)
      for (int n = 0; n < 4; n++) begin
        w = req_word(i, n);
        if (i == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
      end
    cnt0 = 0; cnt1 = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready[2] = (cyc % 3 != 1);
      in_valid[2] = (cnt0 < 4);
      in_valid[6] = (cnt1 < 4);
      if (cnt0 < 4) begin w = req_word(0, cnt0); set_req(0, 2, w[69:40], w[39:8], w[7:0]); end
      if (cnt1 < 4) begin w = req_word(1, cnt1); set_req(1, 2, w[69:40], w[39:8], w[7:0]); end
      @(negedge clk);
      acc0 = in_valid[2] && in_ready[2];
      acc1 = in_valid[6] && in_ready[6];
      if (out_valid[2] && out_ready[2]) begin
        ot  = out_tag[26:18];
        obs = {out_addr[89:60], out_data[95:64], ot[7:0]};
        if (ot[8] == 1'b0) begin
          chk("sb_in0_pending", exp_q0.size() != 0, 1'b1);
          if (exp_q0.size() != 0) chk("sb_in0", obs, exp_q0.pop_front());
        end else begin
          chk("sb_in1_pending", exp_q1.size() != 0, 1'b1);
          if (exp_q1.size() != 0) chk("sb_in1", obs, exp_q1.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc0) cnt0++;
      if (acc1) cnt1++;
    end
    chk("sb_got", got, 8);
    chk("sb_q0_left", exp_q0.size(), 0);
    chk("sb_q1_left", exp_q1.size(), 0);
    in_valid = 8'h00;
    out_ready = 4'hF;

    // asynchronous reset while lane 3 holds a stalled request
    set_req(0, 3, 30'h500, 32'hF0, 8'h77);
    in_valid = 8'h08;
    @(posedge clk); #1;
    out_ready = 4'h7;
    in_valid = 8'h00;
    @(negedge clk);
    chk("stall_before_reset", out_valid[3], 1'b1);
    chk("stall_before_reset_tag", out_tag[35:27], 9'h077);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 4'h0);
    chk("async_reset_tag", out_tag, 36'h0);
    chk("async_reset_addr3", out_addr[119:90], 30'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset_valid", out_valid, 4'h0);
    chk("idle_after_reset_ready", in_ready, 8'h0);
    @(posedge clk); #1;

    // three inputs: rr reaches 2, grant 2, wrap to 0, grant 0
    b_in_tag = {8'hB2, 8'hB1, 8'hB0};
    b_in_addr = {30'h3002, 30'h3001, 30'h3000};
    b_in_valid = 3'b010;
    @(negedge clk);
    chk("n3_ready_in1", b_in_ready, 3'b010);
    @(posedge clk); #1;
    b_in_valid = 3'b101;
    @(negedge clk);
    chk("n3_ready_in2", b_in_ready, 3'b100);
    chk("n3_tag_in1", b_out_tag, 10'h1B1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("n3_ready_wrap_in0", b_in_ready, 3'b001);
    chk("n3_tag_in2", b_out_tag, 10'h2B2);
    chk("n3_addr_in2", b_out_addr, 30'h3002);
    @(posedge clk); #1;
    b_in_valid = 3'b000;
    @(negedge clk);
    chk("n3_tag_in0", b_out_tag, 10'h0B0);
    chk("n3_valid", b_out_valid, 1'b1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
